fp_issue_arbiter: RTL and testbench

- Shares one fixed-latency fused multiply-add datapath between two requesters: port 0 is the core FP issue stage, port 1 is the secondary/vector sequencer.
- The datapath computes dp_rs1*dp_rs2+dp_rs3 and is pipelined, with result valid exactly LAT cycles after issue.
- The block does round-robin arbitration, maps each opcode onto the FMA operands, and tracks in-flight operations so each result returns to its owner with its tag.

---
 rtl/fp_issue_arbiter.sv | 146 ++++++++++++++
 tb/tb_fp_issue_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_issue_arbiter.sv
// Round-robin arbiter that shares one pipelined FMA datapath between two requesters.
// It tracks in-flight ops so each result returns to its owner with its tag.
module fp_issue_arbiter #(
    parameter int LAT   = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [1:0]               req_valid,
    output logic [1:0]               req_ready,
    input  logic [1:0]               req_op0,
    input  logic [1:0]               req_op1,
    input  logic [31:0]              req_a0,
    input  logic [31:0]              req_b0,
    input  logic [31:0]              req_c0,
    input  logic [31:0]              req_a1,
    input  logic [31:0]              req_b1,
    input  logic [31:0]              req_c1,
    input  logic [TAG_W-1:0]         req_tag0,
    input  logic [TAG_W-1:0]         req_tag1,
    output logic                     dp_valid,
    output logic [31:0]              dp_rs1,
    output logic [31:0]              dp_rs2,
    output logic [31:0]              dp_rs3,
    input  logic [31:0]              dp_out,
    output logic [1:0]               res_valid,
    output logic [31:0]              res_data,
    output logic [TAG_W-1:0]         res_tag,
    output logic [$clog2(LAT+1)-1:0] inflight
);
    localparam int          CNT_W  = $clog2(LAT+1);
    localparam logic [31:0] FP_ONE = 32'h3F80_0000;

    logic             lp;
    logic [1:0]       grant;
    logic             issue;
    logic             sel;
    logic [1:0]       sel_op;
    logic [31:0]      sel_a;
    logic [31:0]      sel_b;
    logic [31:0]      sel_c;
    logic [TAG_W-1:0] sel_tag;
    logic             retire;

    logic [LAT-1:0]   trk_valid;
    logic [LAT-1:0]   trk_owner;
    logic [TAG_W-1:0] trk_tag [LAT];

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        grant = 2'b00;
        if (!reset && !flush) begin
            if (req_valid == 2'b11) begin
                grant = lp ? 2'b01 : 2'b10;
            end else begin
                grant = req_valid;
            end
        end
    end

    assign req_ready = grant;
    assign issue     = |(req_valid & grant);
    assign sel       = grant[1];
    assign sel_op    = sel ? req_op1  : req_op0;
    assign sel_a     = sel ? req_a1   : req_a0;
    assign sel_b     = sel ? req_b1   : req_b0;
    assign sel_c     = sel ? req_c1   : req_c0;
    assign sel_tag   = sel ? req_tag1 : req_tag0;

    always_ff @(posedge clk) begin
        if (reset) begin
            lp <= 1'b1;
        end else if (issue) begin
            lp <= sel;
        end
    end

    // FMUL adds zero; FADD/FSUB multiply by 1.0 and add b or -b.
    always_ff @(posedge clk) begin
        if (reset) begin
            dp_valid <= 1'b0;
            dp_rs1   <= '0;
            dp_rs2   <= '0;
            dp_rs3   <= '0;
        end else begin
            dp_valid <= issue;
            if (issue) begin
                dp_rs1 <= sel_a;
                case (sel_op)
                    2'b00: begin
                        dp_rs2 <= sel_b;
                        dp_rs3 <= sel_c;
                    end
                    2'b01: begin
                        dp_rs2 <= sel_b;
                        dp_rs3 <= 32'h0000_0000;
                    end
                    2'b10: begin
                        dp_rs2 <= FP_ONE;
                        dp_rs3 <= sel_b;
                    end
                    default: begin
                        dp_rs2 <= FP_ONE;
                        dp_rs3 <= {~sel_b[31], sel_b[30:0]};
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            trk_valid <= '0;
        end else begin
            for (int i = LAT - 1; i > 0; i--) begin
                trk_valid[i] <= trk_valid[i-1];
            end
            trk_valid[0] <= issue;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) begin
            trk_owner[i] <= trk_owner[i-1];
            trk_tag[i]   <= trk_tag[i-1];
        end
        trk_owner[0] <= sel;
        trk_tag[0]   <= sel_tag;
    end

    assign retire    = trk_valid[LAT-1];
    assign res_valid = (retire && !flush && !reset) ? (trk_owner[LAT-1] ? 2'b10 : 2'b01) : 2'b00;
    assign res_data  = dp_out;
    assign res_tag   = trk_tag[LAT-1];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            inflight <= '0;
        end else if (issue && !retire) begin
            inflight <= inflight + CNT_W'(1);
        end else if (!issue && retire) begin
            inflight <= inflight - CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_fp_issue_arbiter.sv
// Self-checking bench for fp_issue_arbiter: a request-level model predicts grants, results and
// occupancy every cycle, and directed tests pin literal values.
module tb_fp_issue_arbiter;
    localparam int LAT   = 4;
    localparam int TAG_W = 4;
    localparam int CNT_W = $clog2(LAT+1);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             flush = 1'b0;
    logic [1:0]       req_valid = 2'b00;
    logic [1:0]       req_ready;
    logic [1:0]       req_op0 = 2'b00, req_op1 = 2'b00;
    logic [31:0]      req_a0 = '0, req_b0 = '0, req_c0 = '0;
    logic [31:0]      req_a1 = '0, req_b1 = '0, req_c1 = '0;
    logic [TAG_W-1:0] req_tag0 = '0, req_tag1 = '0;
    logic             dp_valid;
    logic [31:0]      dp_rs1, dp_rs2, dp_rs3;
    logic [31:0]      dp_out;
    logic [1:0]       res_valid;
    logic [31:0]      res_data;
    logic [TAG_W-1:0] res_tag;
    logic [CNT_W-1:0] inflight;

    always #5 clk = ~clk;

    fp_issue_arbiter #(.LAT(LAT), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_a0(req_a0), .req_b0(req_b0), .req_c0(req_c0),
        .req_a1(req_a1), .req_b1(req_b1), .req_c1(req_c1),
        .req_tag0(req_tag0), .req_tag1(req_tag1),
        .dp_valid(dp_valid), .dp_rs1(dp_rs1), .dp_rs2(dp_rs2), .dp_rs3(dp_rs3),
        .dp_out(dp_out),
        .res_valid(res_valid), .res_data(res_data), .res_tag(res_tag),
        .inflight(inflight)
    );

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Exact-value float conversions through double precision (normals and zero only).
    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:0] == 31'd0) return 0.0;
        e = {3'b000, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] refResult(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] c);
        case (op)
            2'b00:   return r2f(f2r(a) * f2r(b) + f2r(c));
            2'b01:   return r2f(f2r(a) * f2r(b));
            2'b10:   return r2f(f2r(a) + f2r(b));
            default: return r2f(f2r(a) - f2r(b));
        endcase
    endfunction

    // Datapath stand-in: result appears LAT cycles after the issue cycle, killed ops included.
    logic [31:0] dp_pipe [LAT-1];
    always @(posedge clk) begin
        for (int i = LAT - 2; i > 0; i--) dp_pipe[i] <= dp_pipe[i-1];
        dp_pipe[0] <= dp_valid ? r2f(f2r(dp_rs1) * f2r(dp_rs2) + f2r(dp_rs3)) : 32'hDEAD_BEEF;
    end
    assign dp_out = dp_pipe[LAT-2];

    typedef struct {
        int               due;
        logic             owner;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } pend_t;

    pend_t            pend[$];
    logic [31:0]      log_data[$];
    logic [TAG_W-1:0] log_tag[$];
    logic             log_owner[$];
    int               log_inflight[$];

    int cyc      = 0;
    bit armed    = 1'b0;
    int last_m   = 1;
    bit prev_iss = 1'b0;

    always @(negedge clk) begin : monitor
        int          winner;
        logic [1:0]  exp_ready;
        logic [1:0]  exp_res;
        pend_t       p;
        cyc++;
        winner = -1;
        if (!reset && !flush) begin
            if (req_valid[0] && req_valid[1]) winner = 1 - last_m;
            else if (req_valid[0])            winner = 0;
            else if (req_valid[1])            winner = 1;
        end
        exp_ready = (winner >= 0) ? (2'b01 << winner) : 2'b00;
        if (armed) begin
            checkOutput("inflight", 32'(inflight), pend.size());
            exp_res = 2'b00;
            if (pend.size() > 0 && pend[0].due == cyc && !flush && !reset) begin
                exp_res = pend[0].owner ? 2'b10 : 2'b01;
                checkOutput("res_data", res_data, pend[0].data);
                checkOutput("res_tag", 32'(res_tag), 32'(pend[0].tag));
            end
            checkOutput("res_valid", 32'(res_valid), 32'(exp_res));
            checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
            checkOutput("dp_valid", 32'(dp_valid), 32'(prev_iss));
        end
        if (pend.size() > 0 && pend[0].due == cyc) void'(pend.pop_front());
        if (res_valid != 2'b00) begin
            log_data.push_back(res_data);
            log_tag.push_back(res_tag);
            log_owner.push_back(res_valid[1]);
        end
        log_inflight.push_back(int'(inflight));
        if (reset || flush) begin
            pend.delete();
        end else if (winner >= 0) begin
            p.due   = cyc + LAT;
            p.owner = (winner == 1);
            p.tag   = (winner == 1) ? req_tag1 : req_tag0;
            p.data  = (winner == 1) ? refResult(req_op1, req_a1, req_b1, req_c1)
                                    : refResult(req_op0, req_a0, req_b0, req_c0);
            pend.push_back(p);
        end
        if (reset) last_m = 1;
        else if (winner >= 0) last_m = winner;
        prev_iss = (winner >= 0);
        if (reset) armed = 1'b1;
    end

    task automatic applyStimulus(input logic [1:0] v, input logic fl, input logic rs);
        req_valid = v;
        flush     = fl;
        reset     = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic setPort0(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [TAG_W-1:0] tag);
        req_op0 = op; req_a0 = a; req_b0 = b; req_c0 = c; req_tag0 = tag;
    endtask

    task automatic setPort1(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [TAG_W-1:0] tag);
        req_op1 = op; req_a1 = a; req_b1 = b; req_c1 = c; req_tag1 = tag;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(2'b00, 1'b0, 1'b0);
    endtask

    int mark;
    int peak;
    int tags_exp [6];
    logic [1:0]  ops [3];
    logic [31:0] res_exp [3];
    logic [31:0] rs2_exp [3];
    logic [31:0] rs3_exp [3];

    initial begin
        $display("[TB] start");
        applyStimulus(2'b00, 1'b0, 1'b1);
        applyStimulus(2'b00, 1'b0, 1'b1);
        applyStimulus(2'b00, 1'b0, 1'b0);
        checkOutput("rst_inflight", 32'(inflight), 0);
        checkOutput("rst_dp_valid", 32'(dp_valid), 0);
        checkOutput("rst_res_valid", 32'(res_valid), 0);

        // Single FMADD on port 0: 1.5*2.0+0.5 = 3.5
        setPort0(2'b00, 32'h3FC0_0000, 32'h4000_0000, 32'h3F00_0000, 4'd3);
        applyStimulus(2'b01, 1'b0, 1'b0);
        checkOutput("t1_dp_valid", 32'(dp_valid), 1);
        checkOutput("t1_rs3", dp_rs3, 32'h3F00_0000);
        checkOutput("t1_inflight1", 32'(inflight), 1);
        idle(LAT - 1);
        checkOutput("t1_res_valid", 32'(res_valid), 32'h1);
        checkOutput("t1_res_data", res_data, 32'h4060_0000);
        checkOutput("t1_res_tag", 32'(res_tag), 3);
        idle(1);
        checkOutput("t1_inflight0", 32'(inflight), 0);

        // Opcode mapping on port 1
        ops     = '{2'b01, 2'b10, 2'b11};
        res_exp = '{32'h40C0_0000, 32'h4080_0000, 32'h4000_0000};
        rs2_exp = '{32'h4000_0000, 32'h3F80_0000, 32'h3F80_0000};
        rs3_exp = '{32'h0000_0000, 32'h3F80_0000, 32'hBF80_0000};
        for (int k = 0; k < 3; k++) begin
            if (k == 0) setPort1(ops[k], 32'h4040_0000, 32'h4000_0000, 32'h4120_0000, TAG_W'(k + 1));
            else        setPort1(ops[k], 32'h4040_0000, 32'h3F80_0000, 32'h4120_0000, TAG_W'(k + 1));
            mark = log_data.size();
            applyStimulus(2'b10, 1'b0, 1'b0);
            checkOutput("t2_rs2", dp_rs2, rs2_exp[k]);
            checkOutput("t2_rs3", dp_rs3, rs3_exp[k]);
            idle(LAT);
            checkOutput("t2_count", log_data.size() - mark, 1);
            if (log_data.size() > mark) begin
                checkOutput("t2_data", log_data[mark], res_exp[k]);
                checkOutput("t2_owner", 32'(log_owner[mark]), 1);
            end
        end

        // Contention: both valid for 6 cycles, grants alternate starting with port 0
        mark = log_data.size();
        peak = log_inflight.size();
        for (int k = 0; k < 6; k++) begin
            setPort0(2'b01, 32'h4000_0000, 32'h4000_0000, 32'h0, TAG_W'(k));
            setPort1(2'b10, 32'h3F80_0000, 32'h3F80_0000, 32'h0, TAG_W'(8 + k));
            tags_exp[k] = (k % 2 == 0) ? k : 8 + k;
            applyStimulus(2'b11, 1'b0, 1'b0);
        end
        idle(LAT + 1);
        checkOutput("t3_count", log_data.size() - mark, 6);
        if (log_data.size() >= mark + 6) begin
            for (int k = 0; k < 6; k++) begin
                checkOutput("t3_owner", 32'(log_owner[mark + k]), k % 2);
                checkOutput("t3_tag", 32'(log_tag[mark + k]), tags_exp[k]);
                checkOutput("t3_data", log_data[mark + k], (k % 2 == 0) ? 32'h4080_0000 : 32'h4000_0000);
            end
        end
        begin
            int mx = 0;
            for (int i = peak; i < log_inflight.size(); i++) if (log_inflight[i] > mx) mx = log_inflight[i];
            checkOutput("t3_peak_inflight", mx, LAT);
        end

        // Flush with 3 ops in flight
        mark = log_data.size();
        for (int k = 0; k < 3; k++) begin
            setPort0(2'b00, 32'h4000_0000, 32'h4000_0000, 32'h3F80_0000, TAG_W'(k + 1));
            applyStimulus(2'b01, 1'b0, 1'b0);
        end
        checkOutput("t4_inflight_pre", 32'(inflight), 3);
        req_valid = 2'b11;
        flush     = 1'b1;
        #1;
        checkOutput("t4_flush_ready", 32'(req_ready), 0);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        flush     = 1'b0;
        #1;
        checkOutput("t4_inflight_post", 32'(inflight), 0);
        idle(LAT + 1);
        checkOutput("t4_no_results", log_data.size() - mark, 0);
        setPort1(2'b00, 32'h4000_0000, 32'h4000_0000, 32'h3F80_0000, 4'd5);
        applyStimulus(2'b10, 1'b0, 1'b0);
        idle(LAT);
        checkOutput("t4_after_count", log_data.size() - mark, 1);
        if (log_data.size() > mark) begin
            checkOutput("t4_after_data", log_data[mark], 32'h40A0_0000);
            checkOutput("t4_after_tag", 32'(log_tag[mark]), 5);
        end

        // Reset mid-stream; port 0 won last so only reset makes port 0 win the next tie
        mark = log_data.size();
        setPort1(2'b01, 32'h4040_0000, 32'h4040_0000, 32'h0, 4'd6);
        applyStimulus(2'b10, 1'b0, 1'b0);
        setPort0(2'b01, 32'h4040_0000, 32'h4000_0000, 32'h0, 4'd7);
        applyStimulus(2'b01, 1'b0, 1'b0);
        req_valid = 2'b11;
        reset     = 1'b1;
        #1;
        checkOutput("t5_reset_ready", 32'(req_ready), 0);
        checkOutput("t5_reset_res", 32'(res_valid), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("t5_dp_valid", 32'(dp_valid), 0);
        checkOutput("t5_rs1", dp_rs1, 0);
        checkOutput("t5_rs2", dp_rs2, 0);
        checkOutput("t5_rs3", dp_rs3, 0);
        checkOutput("t5_inflight", 32'(inflight), 0);
        checkOutput("t5_res_valid", 32'(res_valid), 0);
        checkOutput("t5_tie_grant", 32'(req_ready), 32'h1);
        applyStimulus(2'b11, 1'b0, 1'b0);
        idle(LAT + 1);
        checkOutput("t5_count", log_data.size() - mark, 1);
        if (log_data.size() > mark) begin
            checkOutput("t5_owner", 32'(log_owner[mark]), 0);
            checkOutput("t5_tag", 32'(log_tag[mark]), 7);
        end

        // Port 1 streams 8 back-to-back ops with tags 0..7
        mark = log_data.size();
        for (int k = 0; k < 8; k++) begin
            setPort1(2'b01, 32'h4000_0000, 32'h4040_0000, 32'h0, TAG_W'(k));
            applyStimulus(2'b10, 1'b0, 1'b0);
            checkOutput("t6_no_bubble", 32'(dp_valid), 1);
        end
        idle(LAT);
        checkOutput("t6_count", log_data.size() - mark, 8);
        if (log_data.size() >= mark + 8) begin
            for (int k = 0; k < 8; k++) begin
                checkOutput("t6_tag", 32'(log_tag[mark + k]), k);
                checkOutput("t6_owner", 32'(log_owner[mark + k]), 1);
                checkOutput("t6_data", log_data[mark + k], 32'h40C0_0000);
            end
        end

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
